// File: rtl/iconn_switch_node.sv
// Buffered 2x2 routing node: per-input FIFOs, address-bit steering,
// per-output arbitration and registered valid/ready outputs.
module iconn_switch_node #(
    parameter int unsigned NODE_ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned ADDR_BIT_ID     = 0,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned ARB_MODE        = 1,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NODE_ADDR_WIDTH-1:0] ain [0:1],
    input  logic [DATA_WIDTH-1:0]      din [0:1],
    input  logic [1:0]                 din_valid,
    output logic [1:0]                 din_ready,
    output logic [NODE_ADDR_WIDTH-1:0] aout [0:1],
    output logic [DATA_WIDTH-1:0]      dout [0:1],
    output logic [1:0]                 dout_valid,
    input  logic [1:0]                 dout_ready,
    output logic [CNT_WIDTH-1:0]       conflict_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [NODE_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]      data;
    } flit_t;

    flit_t             mem [2][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr [2];
    logic [PTR_W-1:0]  wr_ptr [2];
    logic [FCNT_W-1:0] count [2];
    logic [1:0]        rr_ptr;

    flit_t      in_flit [2];
    flit_t      head [2];
    logic [1:0] full;
    logic [1:0] not_empty;
    logic [1:0] head_dst;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] req [2];
    logic [1:0] can_load;
    logic [1:0] grant_vld;
    logic [1:0] grant_src;
    logic [1:0] contested;

    assign din_ready = ~full;

    // FIFO status, head flits and routing decision per input
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            in_flit[i]   = '{addr: ain[i], data: din[i]};
            head[i]      = mem[i][rd_ptr[i]];
            not_empty[i] = (count[i] != '0);
            full[i]      = (count[i] == FCNT_W'(FIFO_DEPTH));
            head_dst[i]  = head[i].addr[ADDR_BIT_ID];
            push[i]      = din_valid[i] && !full[i];
        end
    end

    // Per-output candidate selection and arbitration
    always_comb begin
        pop       = '0;
        grant_vld = '0;
        grant_src = '0;
        contested = '0;
        can_load  = '0;
        for (int i = 0; i < 2; i++) begin
            req[i] = '0;
        end
        for (int j = 0; j < 2; j++) begin
            can_load[j] = !dout_valid[j] || dout_ready[j];
            for (int i = 0; i < 2; i++) begin
                req[i][j] = not_empty[i] && (head_dst[i] == 1'(j)) && can_load[j];
            end
            contested[j] = req[0][j] && req[1][j];
            grant_vld[j] = req[0][j] || req[1][j];
            if (contested[j]) begin
                grant_src[j] = (ARB_MODE == 0) ? 1'b0 : rr_ptr[j];
            end else begin
                grant_src[j] = req[1][j];
            end
            if (grant_vld[j]) begin
                pop[grant_src[j]] = 1'b1;
            end
        end
    end

    // FIFO storage; occupancy is tracked separately so no reset is needed here
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_flit[i];
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                count[i] <= count[i] + FCNT_W'(push[i]) - FCNT_W'(pop[i]);
            end
        end
    end

    // Output registers: load on grant, clear when the downstream drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= '0;
            for (int j = 0; j < 2; j++) begin
                aout[j] <= '0;
                dout[j] <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (grant_vld[j]) begin
                    aout[j]       <= head[grant_src[j]].addr;
                    dout[j]       <= head[grant_src[j]].data;
                    dout_valid[j] <= 1'b1;
                end else if (dout_ready[j]) begin
                    dout_valid[j] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointers move only on contested grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (ARB_MODE != 0 && contested[j]) begin
                    rr_ptr[j] <= ~grant_src[j];
                end
            end
        end
    end

    // Saturating count of cycles with a real arbitration loss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if ((|contested) && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_iconn_switch_node.sv
// Self-checking bench for iconn_switch_node: vector table plus multi-cycle sequences.
module tb_iconn_switch_node;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ain [0:1];
    logic [63:0] din [0:1];
    logic [1:0]  din_valid;
    logic [1:0]  din_ready;
    logic [4:0]  aout [0:1];
    logic [63:0] dout [0:1];
    logic [1:0]  dout_valid;
    logic [1:0]  dout_ready;
    logic [15:0] conflict_cnt;

    logic [1:0]  s_din_ready;
    logic [4:0]  s_aout [0:1];
    logic [63:0] s_dout [0:1];
    logic [1:0]  s_dout_valid;
    logic [3:0]  s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    iconn_switch_node dut (
        .clk(clk), .rst_n(rst_n), .ain(ain), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .aout(aout), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .conflict_cnt(conflict_cnt)
    );

    iconn_switch_node #(.ARB_MODE(0), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .ain(ain), .din(din), .din_valid(din_valid),
        .din_ready(s_din_ready), .aout(s_aout), .dout(s_dout), .dout_valid(s_dout_valid),
        .dout_ready(dout_ready), .conflict_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        din_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  vin;
        logic [4:0]  a0, a1;
        logic [63:0] d0, d1;
        logic [1:0]  evld;
        logic [4:0]  ea0;
        logic [63:0] ed0;
        logic [4:0]  ea1;
        logic [63:0] ed1;
        logic [15:0] ecnt;
    } vec_t;

    vec_t        vecs [6];
    logic [63:0] got [$];
    int          k0, k1;
    logic        ok;

    initial begin
        vecs[0] = '{2'b11, 5'h00, 5'h01, 64'h1111, 64'h2222, 2'b11, 5'h00, 64'h1111, 5'h01, 64'h2222, 16'd0};
        vecs[1] = '{2'b11, 5'h01, 5'h00, 64'h3333, 64'h4444, 2'b11, 5'h00, 64'h4444, 5'h01, 64'h3333, 16'd0};
        vecs[2] = '{2'b11, 5'h1E, 5'h1F, 64'h5555, 64'h6666, 2'b11, 5'h1E, 64'h5555, 5'h1F, 64'h6666, 16'd0};
        vecs[3] = '{2'b11, 5'h15, 5'h0A, 64'h7777, 64'h8888, 2'b11, 5'h0A, 64'h8888, 5'h15, 64'h7777, 16'd0};
        vecs[4] = '{2'b10, 5'h00, 5'h02, 64'h0,    64'h9999, 2'b01, 5'h02, 64'h9999, 5'h00, 64'h0,    16'd0};
        vecs[5] = '{2'b11, 5'h03, 5'h11, 64'hAAAA, 64'hBBBB, 2'b10, 5'h00, 64'h0,    5'h03, 64'hAAAA, 16'd1};

        rst_n      = 1'b0;
        din_valid  = 2'b00;
        dout_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            ain[i] = '0;
            din[i] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("reset_dout_valid", 64'(dout_valid), 64'h0);
        chk("reset_din_ready", 64'(din_ready), 64'h3);
        chk("reset_cnt", 64'(conflict_cnt), 64'h0);
        chk("reset_dout0", dout[0], 64'h0);
        chk("reset_aout1", 64'(aout[1]), 64'h0);
        rst_n = 1'b1;

        // Table: one-cycle injections, result two cycles later
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            ain[0] = vecs[v].a0; ain[1] = vecs[v].a1;
            din[0] = vecs[v].d0; din[1] = vecs[v].d1;
            din_valid = vecs[v].vin;
            @(negedge clk);
            din_valid = 2'b00;
            chk($sformatf("vec%0d_early_valid", v), 64'(dout_valid), 64'h0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", v), 64'(dout_valid), 64'(vecs[v].evld));
            if (vecs[v].evld[0]) begin
                chk($sformatf("vec%0d_aout0", v), 64'(aout[0]), 64'(vecs[v].ea0));
                chk($sformatf("vec%0d_dout0", v), dout[0], vecs[v].ed0);
            end
            if (vecs[v].evld[1]) begin
                chk($sformatf("vec%0d_aout1", v), 64'(aout[1]), 64'(vecs[v].ea1));
                chk($sformatf("vec%0d_dout1", v), dout[1], vecs[v].ed1);
            end
            chk($sformatf("vec%0d_cnt", v), 64'(conflict_cnt), 64'(vecs[v].ecnt));
            repeat (3) @(negedge clk);
        end

        // Round-robin conflict: both inputs stream to output 0 for 8 cycles
        do_reset();
        dout_ready = 2'b11;
        got.delete();
        k0 = 0; k1 = 0; ok = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (dout_valid[0]) got.push_back(dout[0]);
            if (dout_valid[1]) ok = 1'b0;
            if (c < 8) begin
                ain[0] = 5'h00; ain[1] = 5'h02;
                din[0] = 64'hA000_0000_0000_0000 | 64'(k0);
                din[1] = 64'hB000_0000_0000_0000 | 64'(k1);
                din_valid = 2'b11;
                if (din_ready[0]) k0++;
                if (din_ready[1]) k1++;
            end else begin
                din_valid = 2'b00;
            end
        end
        chk("rr_out1_idle", 64'(ok), 64'h1);
        chk("rr_accept0", 64'(k0), 64'd5);
        chk("rr_accept1", 64'(k1), 64'd5);
        chk("rr_count", 64'(got.size()), 64'd10);
        for (int n = 0; n < got.size() && n < 10; n++) begin
            chk($sformatf("rr_flit%0d", n), got[n],
                ((n % 2 == 0) ? 64'hA000_0000_0000_0000 : 64'hB000_0000_0000_0000) | 64'(n / 2));
        end
        chk("rr_conflict_cnt", 64'(conflict_cnt), 64'd9);

        // Backpressure on output 0 while input 0 streams
        do_reset();
        dout_ready = 2'b10;
        k0 = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                chk($sformatf("bp_din_ready_c%0d", c), 64'(din_ready[0]), 64'h0);
                chk($sformatf("bp_hold_c%0d", c), dout[0], 64'hC000_0000_0000_0000);
                chk($sformatf("bp_valid_c%0d", c), 64'(dout_valid[0]), 64'h1);
            end
            ain[0] = 5'h00;
            din[0] = 64'hC000_0000_0000_0000 | 64'(k0);
            din_valid = 2'b01;
            if (din_ready[0]) k0++;
        end
        chk("bp_accepted", 64'(k0), 64'd3);
        got.delete();
        din_valid  = 2'b00;
        dout_ready = 2'b11;
        for (int c = 0; c < 6; c++) begin
            if (dout_valid[0]) got.push_back(dout[0]);
            @(negedge clk);
        end
        chk("bp_drain_count", 64'(got.size()), 64'd3);
        for (int n = 0; n < got.size() && n < 3; n++) begin
            chk($sformatf("bp_drain%0d", n), got[n], 64'hC000_0000_0000_0000 | 64'(n));
        end

        // Saturation on the 4-bit counter (fixed priority), no wrap on the 16-bit one
        do_reset();
        dout_ready = 2'b11;
        k0 = 0; k1 = 0; ok = 1'b1;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (s_dout_valid[0] && s_dout[0][63:60] != 4'hD) ok = 1'b0;
            ain[0] = 5'h00; ain[1] = 5'h00;
            din[0] = 64'hD000_0000_0000_0000 | 64'(k0);
            din[1] = 64'hE000_0000_0000_0000 | 64'(k1);
            din_valid = 2'b11;
            if (din_ready[0]) k0++;
            if (din_ready[1]) k1++;
        end
        @(negedge clk);
        din_valid = 2'b00;
        chk("sat_cnt", 64'(s_cnt), 64'd15);
        chk("sat_fixed_prio", 64'(ok), 64'h1);
        chk("sat_out1_idle", 64'(s_dout_valid[1]), 64'h0);
        chk("nosat_cnt", 64'(conflict_cnt), 64'd21);

        // Reset mid-stream with both FIFOs holding flits
        do_reset();
        dout_ready = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ain[0] = 5'h00; ain[1] = 5'h01;
            din[0] = 64'hF0 + 64'(c); din[1] = 64'hF8 + 64'(c);
            din_valid = 2'b11;
        end
        @(negedge clk);
        din_valid = 2'b00;
        chk("pre_rst_valid", 64'(dout_valid), 64'h3);
        chk("pre_rst_full", 64'(din_ready), 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(dout_valid), 64'h0);
        chk("rst_async_ready", 64'(din_ready), 64'h3);
        chk("rst_async_cnt", 64'(conflict_cnt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dout_ready = 2'b11;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_idle_c%0d", c), 64'(dout_valid), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
